// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: stage count and per-stage slice width.
package adder_pkg;

  function automatic int stages(input int width, input int bps);
    return (width + bps - 1) / bps;
  endfunction

  // The final stage takes whatever bits remain, so it may be narrower than bps.
  function automatic int slice_width(input int k, input int width, input int bps);
    int remaining;
    remaining = width - k * bps;
    return (remaining < bps) ? remaining : bps;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple of full adders; also exposes the carry entering the slice MSB.
module adder_slice
  import adder_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         c_o,
  output logic         c_msb_o
);

  logic carry;
  logic carry_msb;

  always_comb begin
    carry     = c_i;
    carry_msb = c_i;
    sum_o     = '0;
    for (int i = 0; i < W; i++) begin
      carry_msb = carry;
      sum_o[i]  = a_i[i] ^ b_i[i] ^ carry;
      carry     = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o     = carry;
    c_msb_o = carry_msb;
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Ripple-carry adder cut into BITS_PER_STAGE-bit pipeline stages with a valid/ready handshake.
// Define ADDER_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stages(WIDTH, BITS_PER_STAGE);

  // The whole pipeline moves as one unit, so a single enable covers every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * BITS_PER_STAGE;
    localparam int SW  = slice_width(gi, WIDTH, BITS_PER_STAGE);
    localparam int HI  = LO + SW;
    localparam int REM = WIDTH - HI;

    logic [SW-1:0] op_a;
    logic [SW-1:0] op_b;
    logic [SW-1:0] slice_sum;
    logic          carry_in;
    logic          carry_out;
    logic          carry_msb;
    logic          valid_in;
    logic [HI-1:0] sum_d;

    logic          valid_q;
    logic          carry_q;
    logic [HI-1:0] sum_q;

    if (gi == 0) begin : g_src
      assign op_a     = a[SW-1:0];
      assign op_b     = b[SW-1:0];
      assign carry_in = cin;
      assign valid_in = in_valid;
      assign sum_d    = slice_sum;
    end else begin : g_src
      // Skew registers of the previous stage hold operand bits [LO..WIDTH-1] shifted down to bit 0.
      assign op_a     = g_stage[gi-1].g_skew.a_q[SW-1:0];
      assign op_b     = g_stage[gi-1].g_skew.b_q[SW-1:0];
      assign carry_in = g_stage[gi-1].carry_q;
      assign valid_in = g_stage[gi-1].valid_q;
      assign sum_d    = {slice_sum, g_stage[gi-1].sum_q};
    end

    adder_slice #(.W(SW)) u_slice (
      .a_i    (op_a),
      .b_i    (op_b),
      .c_i    (carry_in),
      .sum_o  (slice_sum),
      .c_o    (carry_out),
      .c_msb_o(carry_msb)
    );

    // Data registers only load on a real operation so outputs hold through bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_in;
        if (valid_in) begin
          carry_q <= carry_out;
          sum_q   <= sum_d;
        end
      end
    end

    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (gi == 0) begin : g_pick
        assign a_d = a[WIDTH-1:HI];
        assign b_d = b[WIDTH-1:HI];
      end else begin : g_pick
        assign a_d = g_stage[gi-1].g_skew.a_q[WIDTH-LO-1:SW];
        assign b_d = g_stage[gi-1].g_skew.b_q[WIDTH-LO-1:SW];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && valid_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef ADDER_OVERFLOW_EN
    if (gi == STAGES - 1) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance && valid_in) begin
          ovf_q <= carry_msb ^ carry_out;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
`ifdef ADDER_OVERFLOW_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: three instances (8/2, 1/1, 7/3) sharing one queue-based scoreboard.
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic       in_valid[3];
  logic       out_ready[3];
  logic       cin[3];
  logic [7:0] a[3];
  logic [7:0] b[3];

  logic       in_ready[3];
  logic       out_valid[3];
  logic       cout[3];
  logic       ovf[3];
  logic [7:0] sum[3];

  logic       rdy0, rdy1, rdy2, vld0, vld1, vld2, co0, co1, co2;
  logic [7:0] s0;
  logic       s1;
  logic [6:0] s2;
`ifdef ADDER_OVERFLOW_EN
  logic       ovf0, ovf1, ovf2;
`endif

  always_comb begin
    in_ready[0]  = rdy0;
    in_ready[1]  = rdy1;
    in_ready[2]  = rdy2;
    out_valid[0] = vld0;
    out_valid[1] = vld1;
    out_valid[2] = vld2;
    cout[0]      = co0;
    cout[1]      = co1;
    cout[2]      = co2;
    sum[0]       = s0;
    sum[1]       = {7'b0, s1};
    sum[2]       = {1'b0, s2};
`ifdef ADDER_OVERFLOW_EN
    ovf[0] = ovf0;
    ovf[1] = ovf1;
    ovf[2] = ovf2;
`else
    ovf[0] = 1'b0;
    ovf[1] = 1'b0;
    ovf[2] = 1'b0;
`endif
  end

  pipelined_ripple_adder #(.WIDTH(8), .BITS_PER_STAGE(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy0),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .out_valid(vld0), .out_ready(out_ready[0]),
    .sum(s0), .cout(co0)
`ifdef ADDER_OVERFLOW_EN
    , .ovf(ovf0)
`endif
  );

  pipelined_ripple_adder #(.WIDTH(1), .BITS_PER_STAGE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1),
    .a(a[1][0:0]), .b(b[1][0:0]), .cin(cin[1]), .out_valid(vld1), .out_ready(out_ready[1]),
    .sum(s1), .cout(co1)
`ifdef ADDER_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  pipelined_ripple_adder #(.WIDTH(7), .BITS_PER_STAGE(3)) u_dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2),
    .a(a[2][6:0]), .b(b[2][6:0]), .cin(cin[2]), .out_valid(vld2), .out_ready(out_ready[2]),
    .sum(s2), .cout(co2)
  `ifdef ADDER_OVERFLOW_EN
    , .ovf(ovf2)
  `endif
  );

  // Reference model: {ovf, cout, sum} for instance i.
  function automatic logic [9:0] model(input int i, input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv);
    int   w, m, full, ua, ub;
    logic co, ov;
    logic [7:0] s;
    w    = (i == 0) ? 8 : (i == 1) ? 1 : 7;
    m    = (1 << w) - 1;
    ua   = int'(av) & m;
    ub   = int'(bv) & m;
    full = ua + ub + int'(cv);
    s    = 8'(full & m);
    co   = ((full >> w) & 1) != 0;
    ov   = 1'b0;
`ifdef ADDER_OVERFLOW_EN
    begin
      int sa, sb, t, half;
      half = 1 << (w - 1);
      sa   = (ua >= half) ? ua - (1 << w) : ua;
      sb   = (ub >= half) ? ub - (1 << w) : ub;
      t    = sa + sb + int'(cv);
      ov   = (t > half - 1) || (t < -half);
    end
`endif
    return {ov, co, s};
  endfunction

  logic [9:0] exp_q[3][$];

  always @(negedge clk) begin
    logic [9:0] got, exp_v;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        exp_q[i].delete();
      end else begin
        if (out_valid[i] && out_ready[i]) begin
          got = {ovf[i], cout[i], sum[i]};
          vectors++;
          if (exp_q[i].size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_extra dut%0d: got {ovf,cout,sum}=%h, none expected", i, got);
          end else begin
            exp_v = exp_q[i].pop_front();
            if (got !== exp_v) begin
              miscompares++;
              $display("FAIL scoreboard dut%0d: got {ovf,cout,sum}=%h, required %h", i, got, exp_v);
            end
          end
        end
        if (in_valid[i] && in_ready[i])
          exp_q[i].push_back(model(i, a[i], b[i], cin[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1; cin[i] = 1'b0; a[i] = '0; b[i] = '0;
    end
    rst = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid[i] !== 1'b0 || sum[i] !== 8'h00 || cout[i] !== 1'b0 || ovf[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got v=%b sum=%h cout=%b ovf=%b, required 0", i,
                 out_valid[i], sum[i], cout[i], ovf[i]);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release dut%0d: got in_ready=%b out_valid=%b, required 1/0", i,
                 in_ready[i], out_valid[i]);
      end
    end
  endtask

  // One op on dut8, then check out_valid stays low until 3 edges after acceptance.
  task automatic run_latency(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input logic cv, input logic [9:0] req);
    step();
    a[0] = av; b[0] = bv; cin[0] = cv; in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      vectors++;
      if (out_valid[0] !== (k == 3)) begin
        miscompares++;
        $display("FAIL %s_latency: edge E+%0d out_valid=%b, required %b", name, k, out_valid[0], k == 3);
      end
    end
    vectors++;
    if ({ovf[0], cout[0], sum[0]} !== req) begin
      miscompares++;
      $display("FAIL %s_result: got {ovf,cout,sum}=%h, required %h", name, {ovf[0], cout[0], sum[0]}, req);
    end
  endtask

  task automatic test_basic();
    out_ready[0] = 1'b1;
    run_latency("add_5a_3c", 8'h5A, 8'h3C, 1'b0, {1'b0, 1'b0, 8'h96});
`ifdef ADDER_OVERFLOW_EN
    run_latency("add_ff_00_c", 8'hFF, 8'h00, 1'b1, {1'b0, 1'b1, 8'h00});
`else
    run_latency("add_ff_00_c", 8'hFF, 8'h00, 1'b1, {1'b0, 1'b1, 8'h00});
`endif
  endtask

  task automatic test_ovf();
`ifdef ADDER_OVERFLOW_EN
    run_latency("ovf_80_80", 8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
    run_latency("ovf_7f_01", 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
    run_latency("ovf_10_20", 8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'h30});
`endif
  endtask

  task automatic test_back_to_back();
    int run, gap, ended;
    run = 0; gap = 0; ended = 0;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (out_valid[0]) begin
        if (ended) gap = 1;
        run++;
      end else if (run > 0) begin
        ended = 1;
      end
      in_valid[0] = (c < 16);
      a[0] = 8'($urandom); b[0] = 8'($urandom); cin[0] = 1'($urandom);
    end
    vectors++;
    if (run != 16 || gap != 0) begin
      miscompares++;
      $display("FAIL back_to_back_run: got %0d valid cycles (gap=%0d), required 16 contiguous", run, gap);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] first;
    int drained;
    out_ready[0] = 1'b0;
    first = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      a[0] = 8'h21 + 8'(k * 17); b[0] = 8'h47 + 8'(k * 5); cin[0] = 1'(k); in_valid[0] = 1'b1;
      if (k == 0) first = model(0, a[0], b[0], cin[0]);
    end
    step();
    in_valid[0] = 1'b0;
    step();
    for (int s = 0; s < 5; s++) begin
      vectors++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || {ovf[0], cout[0], sum[0]} !== first) begin
        miscompares++;
        $display("FAIL backpressure_hold cycle %0d: got rdy=%b v=%b out=%h, required 0/1/%h", s,
                 in_ready[0], out_valid[0], {ovf[0], cout[0], sum[0]}, first);
      end
      a[0] = 8'($urandom); b[0] = 8'($urandom); in_valid[0] = 1'b1;
      step();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    drained = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid[0]) drained++;
      step();
    end
    vectors++;
    if (drained != 3) begin
      miscompares++;
      $display("FAIL backpressure_drain: got %0d results, required 3", drained);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      a[0] = 8'h33 + 8'(k); b[0] = 8'h44; cin[0] = 1'b1; in_valid[0] = 1'b1;
    end
    step();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 10 && !out_valid[0]; k++) step();
    vectors++;
    if (out_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_fill: got out_valid=%b, required 1", out_valid[0]);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0 || sum[0] !== 8'h00 || cout[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_async_reset: got v=%b sum=%h cout=%b, required 0/00/0",
               out_valid[0], sum[0], cout[0]);
    end
    step();
    step();
    rst = 1'b0;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++;
      if (out_valid[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL midflight_stale cycle %0d: got out_valid=%b, required 0", c, out_valid[0]);
      end
    end
    a[0] = 8'h12; b[0] = 8'h34; cin[0] = 1'b0; in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 10 && !out_valid[0]; k++) step();
    vectors++;
    if (out_valid[0] !== 1'b1 || sum[0] !== 8'h46) begin
      miscompares++;
      $display("FAIL midflight_after_reset: got v=%b sum=%h, required 1/46", out_valid[0], sum[0]);
    end
    step();
  endtask

  task automatic test_full_adder();
    logic ea, eb, ec;
    out_ready[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c >= 1 && c <= 8) begin
        ea = 1'((c - 1) & 1); eb = 1'(((c - 1) >> 1) & 1); ec = 1'(((c - 1) >> 2) & 1);
        vectors++;
        if (out_valid[1] !== 1'b1 || sum[1][0] !== (ea ^ eb ^ ec) ||
            cout[1] !== ((ea & eb) | (ea & ec) | (eb & ec))) begin
          miscompares++;
          $display("FAIL full_adder a=%b b=%b cin=%b: got v=%b sum=%b cout=%b", ea, eb, ec,
                   out_valid[1], sum[1][0], cout[1]);
        end
      end else if (c == 9) begin
        vectors++;
        if (out_valid[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL full_adder_idle: got out_valid=%b, required 0", out_valid[1]);
        end
      end
      in_valid[1] = (c < 8);
      a[1] = 8'(c & 1); b[1] = 8'((c >> 1) & 1); cin[1] = 1'((c >> 2) & 1);
    end
  endtask

  task automatic test_uneven();
    int sent;
    sent = 0;
    for (int c = 0; c < 3000 && sent < 200; c++) begin
      step();
      out_ready[2] = ($urandom_range(0, 3) != 0);
      in_valid[2]  = ($urandom_range(0, 4) != 0);
      a[2] = 8'($urandom_range(0, 127)); b[2] = 8'($urandom_range(0, 127)); cin[2] = 1'($urandom);
      #1;
      if (in_valid[2] && in_ready[2]) sent++;
    end
    step();
    in_valid[2] = 1'b0;
    out_ready[2] = 1'b1;
    for (int c = 0; c < 20 && exp_q[2].size() != 0; c++) step();
    vectors++;
    if (sent != 200 || exp_q[2].size() != 0) begin
      miscompares++;
      $display("FAIL uneven_drain: sent %0d (required 200), %0d results outstanding (required 0)",
               sent, exp_q[2].size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_full_adder();
    test_uneven();
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("FAIL final_drain dut%0d: %0d results outstanding, required 0", i, exp_q[i].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

- Parametrised, clocked successor to the single-bit clocked full adder.
- Adds two WIDTH-bit operands plus carry-in through a ripple-carry chain cut into pipeline stages of BITS_PER_STAGE bits each.
- Accepts one operation per cycle and carries a valid/ready handshake on both sides.
- Sits where the 8-bit ripple-carry examples sit, and is the block our VCD assertion flows check for latency and throughput.

## Interface
- WIDTH, default 8: operand and sum width; must be ≥1.
- BITS_PER_STAGE, default 2: bits resolved per pipeline stage; 1..WIDTH.
- STAGES is derived, not a port parameter: ceil(WIDTH/BITS_PER_STAGE).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow; present only with ADDER_OVERFLOW_EN.

## Operation
- Stage k (0..STAGES-1) adds bits [k*BITS_PER_STAGE +: BITS_PER_STAGE] of a and b with the carry registered by stage k-1. Stage 0 uses cin.
- The last stage may be narrower when WIDTH is not a multiple of BITS_PER_STAGE.
- Unconsumed upper operand bits travel forward in skew registers. Already-resolved lower sum bits travel forward in deskew registers. All bits of one operation leave together.
- Each stage holds a valid bit. The pipeline advances as one unit: advance = !out_valid || out_ready.
  - When advance is 1, every stage register loads from its predecessor.
  - When advance is 0, every stage register holds its value.
- in_ready = advance. It is combinational from out_valid and out_ready and never depends on in_valid.
- A transfer occurs when in_valid && in_ready. With in_valid=0 and advance=1, a bubble (valid=0) enters stage 0.
- sum, cout and ovf are driven from last-stage registers only; no combinational path from a, b or cin.
- While out_valid=0, sum, cout and ovf hold their previous values. The bench must not check them then.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, all stage valid bits 0. in_ready=1 while reset is deasserted and out_valid=0.
- Reset mid-operation discards every in-flight operation with no partial output. The first transfer after rst falls is accepted normally.
- Latency: a transfer at edge E sets out_valid after edge E+STAGES-1. With STAGES=1 the result is registered at the accepting edge.
- Throughput: 1 operation per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0:
  - sum, cout, ovf and out_valid stay stable.
  - in_ready=0, and no new transfer is accepted.
- Simultaneous output consume and input accept in the same cycle is legal and loses no data.
- Arithmetic wrap: the (WIDTH+1)-bit result is {cout,sum}. No saturation.

## Configuration
- ADDER_OVERFLOW_EN defined:
  - ovf port exists.
  - ovf = carry into bit WIDTH-1 XOR cout, computed in the last stage and registered with sum.
- ADDER_OVERFLOW_EN undefined: ovf port and its logic are absent. All other behaviour and timing are identical.

## Structure
- Shared package adder_pkg holds:
  - function stages(width, bps) returning ceil(width/bps);
  - function slice_width(k, width, bps) returning the bit count of stage k.
- One sub-module, adder_slice: combinational BITS_PER_STAGE-bit ripple of full adders. Inputs: bit slices of a and b, carry in. Outputs: slice sum, carry out, and carry into the slice MSB (feeds ovf).
- The top level instantiates adder_slice once per stage via generate. It owns all stage, skew and deskew registers plus the valid/advance logic.

## Test plan
- WIDTH=8, BITS_PER_STAGE=2: 0x5A+0x3C, cin=0 -> sum=0x96, cout=0, out_valid asserted after edge E+3. 0xFF+0x00, cin=1 -> sum=0x00, cout=1.
- With ADDER_OVERFLOW_EN: 0x80+0x80 -> sum=0x00, cout=1, ovf=1. 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. 0x10+0x20 -> ovf=0.
- Back-to-back: 16 transfers on consecutive cycles with out_ready=1 -> 16 consecutive out_valid cycles, results in order and equal to a+b+cin.
- Backpressure: hold out_ready=0 for 5 cycles with 3 operations in flight -> in_ready=0 and outputs frozen throughout. On release, all three drain in order with no loss or duplication.
- Reset mid-flight: assert rst between clock edges with 3 operations in flight -> out_valid=0 and sum=0 immediately. No stale result after rst falls.
- WIDTH=1, BITS_PER_STAGE=1: all 8 combinations of a, b, cin -> sum and cout match the full-adder truth table, each 1 cycle after acceptance. Repeat WIDTH=7, BITS_PER_STAGE=3 (uneven last stage) with 200 random vectors.
